// File: rtl/mod_n_counter_ctrl_if.sv
// Configuration handshake bundle for mod_n_counter_ctrl.
// Master offers a modulus/mode; slave reports ready and bad-modulus errors.
interface mod_n_counter_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_n;
  logic             cfg_oneshot;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_n,
    output cfg_oneshot,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_n,
    input  cfg_oneshot,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/mod_n_counter_ctrl.sv
// Run controller wrapping a mod-N up counter with start/pause/stop.
// Define MODN_CTRL_IRQ_EN to enable the sticky terminal-count irq.
module mod_n_counter_ctrl #(
  parameter int WIDTH     = 4,
  parameter int DEFAULT_N = 10
) (
  input  logic                clk,
  input  logic                reset,
  mod_n_counter_ctrl_if.slave cfg,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic                irq_clr,
  output logic [WIDTH-1:0]    count,
  output logic [WIDTH-1:0]    n_active,
  output logic                tc,
  output logic                busy,
  output logic                done,
  output logic                irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] RST_N = WIDTH'(DEFAULT_N);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] count_d;
  logic             mode_q;
  logic             err_q;
  logic             acc;
  logic             cfg_ok;
  logic             at_last;
  logic             wrap;

  assign cfg.cfg_ready = (state_q == IDLE) || (state_q == DONE);
  assign cfg.cfg_err   = err_q;
  assign busy          = (state_q == RUN) || (state_q == HOLD);
  assign done          = (state_q == DONE);

  assign acc     = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg_ok  = (cfg.cfg_n >= TWO);
  assign at_last = (count == (n_active - ONE));

  // Next state and next count; stop outranks every other request
  always_comb begin
    state_d = state_q;
    count_d = count;
    wrap    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!stop && start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (pause) begin
          state_d = HOLD;
        end else if (at_last) begin
          count_d = '0;
          wrap    = 1'b1;
          state_d = mode_q ? DONE : RUN;
        end else begin
          count_d = count + ONE;
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
        end else if (acc) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter, terminal-count pulse and error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
      err_q <= 1'b0;
    end else begin
      count <= count_d;
      tc    <= wrap;
      err_q <= acc && !cfg_ok;
    end
  end

  // Modulus and mode; a rejected modulus leaves both untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      n_active <= RST_N;
      mode_q   <= 1'b0;
    end else if (acc && cfg_ok) begin
      n_active <= cfg.cfg_n;
      mode_q   <= cfg.cfg_oneshot;
    end
  end

`ifdef MODN_CTRL_IRQ_EN
  // Sticky irq; a wrap on the same edge as irq_clr keeps it set
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (wrap) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`else
  logic irq_clr_unused;
  assign irq_clr_unused = irq_clr;
  assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_mod_n_counter_ctrl.sv
// Randomised + directed bench for mod_n_counter_ctrl.
// A cycle-level reference model predicts every registered output.
module tb_mod_n_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       irq_clr = 1'b0;
  logic [3:0] count;
  logic [3:0] n_active;
  logic       tc;
  logic       busy;
  logic       done;
  logic       irq;

  mod_n_counter_ctrl_if #(.WIDTH(4)) cif ();

  mod_n_counter_ctrl #(
    .WIDTH(4),
    .DEFAULT_N(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg(cif.slave),
    .start(start),
    .stop(stop),
    .pause(pause),
    .irq_clr(irq_clr),
    .count(count),
    .n_active(n_active),
    .tc(tc),
    .busy(busy),
    .done(done),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int  n_vec = 0;
  int  n_bad = 0;
  bit  chk_en = 0;

  // reference model state
  int  e_count;
  int  e_n;
  bit  e_mode;
  bit  m_busy;
  bit  m_hold;
  bit  m_done;
  bit  e_tc;
  bit  e_err;
  bit  e_irq;

`ifdef MODN_CTRL_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  task automatic cmp(string nm, int got, int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit w;
    bit rdy;
    if (reset) begin
      e_count = 0; e_n = 10; e_mode = 0;
      m_busy = 0; m_hold = 0; m_done = 0;
      e_tc = 0; e_err = 0; e_irq = 0;
      return;
    end
    w   = 0;
    rdy = !m_busy;
    e_err = rdy && cif.cfg_valid && (cif.cfg_n < 2);
    if (rdy && cif.cfg_valid && cif.cfg_n >= 2) begin
      e_n    = int'(cif.cfg_n);
      e_mode = cif.cfg_oneshot;
    end
    if (stop) begin
      m_busy = 0; m_hold = 0; m_done = 0; e_count = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_done = 0;
      end else if (m_done && cif.cfg_valid) begin
        m_done = 0;
      end
    end else if (m_hold) begin
      if (!pause) m_hold = 0;
    end else if (pause) begin
      m_hold = 1;
    end else begin
      e_count = (e_count + 1) % e_n;
      if (e_count == 0) begin
        w = 1;
        if (e_mode) begin
          m_busy = 0; m_done = 1;
        end
      end
    end
    e_tc = w;
    if (IRQ_ON) e_irq = w ? 1'b1 : (irq_clr ? 1'b0 : e_irq);
    else e_irq = 0;
  endtask

  // one clock: model follows DUT at the edge, return at negedge
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_cfg(int n, bit os);
    cif.cfg_valid = 1; cif.cfg_n = 4'(n); cif.cfg_oneshot = os;
    step();
    cif.cfg_valid = 0;
  endtask

  // compare every output against the model each cycle
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("count", int'(count), e_count);
      cmp("n_active", int'(n_active), e_n);
      cmp("tc", int'(tc), int'(e_tc));
      cmp("busy", int'(busy), int'(m_busy));
      cmp("done", int'(done), int'(m_done));
      cmp("cfg_ready", int'(cif.cfg_ready), int'(!m_busy));
      cmp("cfg_err", int'(cif.cfg_err), int'(e_err));
      cmp("irq", int'(irq), int'(e_irq));
    end
  end

  initial begin
    cif.cfg_valid = 0; cif.cfg_n = '0; cif.cfg_oneshot = 0;
    @(negedge clk);
    // reset held for two cycles
    step(); step();
    reset = 0;
    chk_en = 1;
    cmp("rst_count", int'(count), 0);
    cmp("rst_n", int'(n_active), 10);
    cmp("rst_ready", int'(cif.cfg_ready), 1);
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_done", int'(done), 0);
    cmp("rst_tc", int'(tc), 0);

    // continuous N=5
    do_cfg(5, 0);
    cmp("c5_n", int'(n_active), 5);
    start = 1; step(); start = 0;
    cmp("c5_busy0", int'(busy), 1);
    cmp("c5_cnt0", int'(count), 0);
    for (int i = 1; i <= 12; i++) begin
      step();
      cmp("c5_cnt", int'(count), i % 5);
      cmp("c5_tc", int'(tc), int'(i % 5 == 0));
      cmp("c5_busy", int'(busy), 1);
    end
    stop = 1; step(); stop = 0;
    cmp("c5_stop_cnt", int'(count), 0);
    cmp("c5_stop_busy", int'(busy), 0);

    // one-shot N=3, run twice
    do_cfg(3, 1);
    for (int r = 0; r < 2; r++) begin
      start = 1; step(); start = 0;
      cmp("os_busy", int'(busy), 1);
      cmp("os_done0", int'(done), 0);
      step(); cmp("os_c1", int'(count), 1);
      step(); cmp("os_c2", int'(count), 2);
      step();
      cmp("os_c0", int'(count), 0);
      cmp("os_tc", int'(tc), 1);
      cmp("os_done", int'(done), 1);
      for (int i = 0; i < 10; i++) begin
        step();
        cmp("os_idle_busy", int'(busy), 0);
        cmp("os_idle_cnt", int'(count), 0);
      end
    end
    stop = 1; step(); stop = 0;
    cmp("os_stop_done", int'(done), 0);

    // pause / stop with N=10 continuous
    do_cfg(10, 0);
    start = 1; step(); start = 0;
    step(); step();
    cmp("p_c2", int'(count), 2);
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      step(); cmp("p_hold", int'(count), 2);
    end
    pause = 0;
    step(); cmp("p_resume", int'(count), 2);
    step(); cmp("p_c3", int'(count), 3);
    stop = 1; step(); stop = 0;
    cmp("p_stop_cnt", int'(count), 0);
    cmp("p_stop_busy", int'(busy), 0);
    stop = 1; start = 1; step(); stop = 0; start = 0;
    cmp("ss_busy", int'(busy), 0);

    // config edge cases
    do_cfg(1, 0);
    cmp("err_pulse", int'(cif.cfg_err), 1);
    cmp("err_n", int'(n_active), 10);
    step();
    cmp("err_clear", int'(cif.cfg_err), 0);
    start = 1; step(); start = 0;
    cif.cfg_valid = 1; cif.cfg_n = 4'd7; cif.cfg_oneshot = 0;
    cmp("run_ready", int'(cif.cfg_ready), 0);
    step(); cif.cfg_valid = 0;
    cmp("run_n", int'(n_active), 10);
    stop = 1; step(); stop = 0;

    // reset mid-count
    do_cfg(6, 0);
    start = 1; step(); start = 0;
    step(); step(); step();
    cmp("mr_c3", int'(count), 3);
    reset = 1; step(); reset = 0;
    cmp("mr_cnt", int'(count), 0);
    cmp("mr_n", int'(n_active), 10);
    cmp("mr_busy", int'(busy), 0);
    cmp("mr_ready", int'(cif.cfg_ready), 1);

    // irq behaviour
    do_cfg(3, 0);
    start = 1; step(); start = 0;
    step(); step(); step();
    cmp("irq_set", int'(irq), int'(IRQ_ON));
    irq_clr = 1;
    step(); cmp("irq_clr", int'(irq), 0);
    step(); step();
    cmp("irq_wrap_clr", int'(irq), int'(IRQ_ON));
    step(); cmp("irq_after", int'(irq), 0);
    irq_clr = 0;
    stop = 1; step(); stop = 0;

    // randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset   = ($urandom_range(0, 299) == 0);
      stop    = ($urandom_range(0, 24) == 0);
      start   = ($urandom_range(0, 3) == 0);
      pause   = ($urandom_range(0, 5) == 0);
      irq_clr = ($urandom_range(0, 7) == 0);
      cif.cfg_valid   = ($urandom_range(0, 3) == 0);
      cif.cfg_n       = 4'($urandom_range(0, 15));
      cif.cfg_oneshot = 1'($urandom_range(0, 1));
      step();
    end
    reset = 0; stop = 0; start = 0; pause = 0; irq_clr = 0;
    cif.cfg_valid = 0;
    step();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
